// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (CPU priority, DMA anti-starvation) in front of a single-port
// word RAM with one-cycle read latency; each access runs IDLE -> ISSUE -> RESP.
module dmem_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_ack_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [31:0]       dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    output logic [DATA_W-1:0] dma_rdata_o,
    output logic              dma_ack_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;         // 1 = DMA owns the current access
    logic              we_q, we_d;
    logic              in_range_q, in_range_d;
    logic [3:0]        starve_q, starve_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;

    logic              grant_dma;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_word;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_in_range;
    logic [DATA_W-1:0] resp_data;

    // DMA wins only when alone or when the CPU has used up its grant budget.
    assign grant_dma    = dma_req_i && (!cpu_req_i || (starve_q == STARVE_LIM));
    assign sel_we       = grant_dma ? dma_we_i    : cpu_we_i;
    assign sel_addr     = grant_dma ? dma_addr_i  : cpu_addr_i;
    assign sel_wdata    = grant_dma ? dma_wdata_i : cpu_wdata_i;
    assign sel_word     = sel_addr >> 2;
    assign sel_in_range = (sel_word >> ADDR_W) == 32'd0;
    assign resp_data    = in_range_q ? mem_rdata_i : '0;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        in_range_d  = in_range_q;
        starve_d    = starve_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!dma_req_i || grant_dma) begin
                    starve_d = 4'd0;
                end else if (cpu_req_i && (starve_q != STARVE_LIM)) begin
                    starve_d = starve_q + 4'd1;
                end
                if (cpu_req_i || dma_req_i) begin
                    owner_d     = grant_dma;
                    we_d        = sel_we;
                    in_range_d  = sel_in_range;
                    mem_addr_d  = sel_word[ADDR_W-1:0];
                    mem_wdata_d = sel_wdata;
                    mem_we_d    = sel_we && sel_in_range;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (owner_q) begin
                    dma_ack_d = 1'b1;
                    if (!we_q) dma_rdata_d = resp_data;
                end else begin
                    cpu_ack_d = 1'b1;
                    if (!we_q) cpu_rdata_d = resp_data;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            in_range_q  <= 1'b0;
            starve_q    <= 4'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            in_range_q  <= in_range_d;
            starve_q    <= starve_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
        end
    end

    assign cpu_rdata_o = cpu_rdata_q;
    assign cpu_ack_o   = cpu_ack_q;
    assign dma_rdata_o = dma_rdata_q;
    assign dma_ack_o   = dma_ack_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized two-port traffic checked
// against a transaction-level memory model and spec latency bounds.
module tb_dmem_arbiter;

    localparam int AW   = 14;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0]   cpu_addr, dma_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata;
    logic          cpu_ack, dma_ack, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    bit   [DW-1:0] ram [0:(1<<AW)-1];
    logic [31:0]   mdl [int];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clock_i(clk), .reset_i(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr),
        .dma_wdata_i(dma_wdata), .dma_rdata_o(dma_rdata), .dma_ack_o(dma_ack),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    // Single-port RAM with registered read.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: accesses are serialized, applied in ack order.
    task automatic model_apply(input bit we, input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] rd);
        int w;
        bit inr;
        inr = (a[31:AW+2] == '0);
        w   = int'(a[AW+1:2]);
        rd  = '0;
        if (we) begin
            if (inr) mdl[w] = d;
        end else if (inr && mdl.exists(w)) begin
            rd = mdl[w];
        end
    endtask

    task automatic do_access(input bit port, input bit we, input logic [31:0] addr,
                             input logic [31:0] wd, output int lat, output int we_cnt,
                             output logic [AW-1:0] maddr, output logic [31:0] rd,
                             output int other_ack);
        lat = 0; we_cnt = 0; maddr = '0; rd = '0; other_ack = 0;
        if (!port) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end else begin
            dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wd;
        end
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 1) maddr = mem_addr;
            if (mem_we) we_cnt++;
            if (port ? cpu_ack : dma_ack) other_ack++;
            if (port ? dma_ack : cpu_ack) begin
                lat = i;
                rd  = port ? dma_rdata : cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        $display("access port=%0d we=%0d addr=%h lat=%0d rd=%h", port, we, addr, lat, rd);
    endtask

    initial begin
        int lat, wec, oth, k, last_dma, cw, dw;
        logic [AW-1:0] ma;
        logic [31:0] rd, exp_rd, c_rd_exp, d_rd_exp, c_a, d_a, c_d, d_d;
        bit cp, dp, c_we, d_we;

        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        repeat (3) step();
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_dma_ack", dma_ack, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dma_rdata", dma_rdata, 0);
        rst = 1'b0;
        step();

        // CPU store then load
        do_access(0, 1, 32'h10, 32'hDEADBEEF, lat, wec, ma, rd, oth);
        chk("st_lat", lat, 3);
        chk("st_we_cycles", wec, 1);
        chk("st_mem_addr", ma, 4);
        chk("st_no_dma_ack", oth, 0);
        do_access(0, 0, 32'h10, 32'h0, lat, wec, ma, rd, oth);
        chk("ld_lat", lat, 3);
        chk("ld_we_cycles", wec, 0);
        chk("ld_rdata", rd, 32'hDEADBEEF);

        // DMA write while CPU idle, then CPU reads it back
        do_access(1, 1, 32'h20, 32'h12345678, lat, wec, ma, rd, oth);
        chk("dma_wr_lat", lat, 3);
        chk("dma_wr_addr", ma, 8);
        chk("dma_wr_we", wec, 1);
        chk("dma_no_cpu_ack", oth, 0);
        do_access(0, 0, 32'h20, 32'h0, lat, wec, ma, rd, oth);
        chk("cpu_ld_dma_data", rd, 32'h12345678);
        chk("dma_rdata_after_wr", dma_rdata, 0);

        // Out-of-range store / load
        do_access(0, 1, 32'h0001_0000, 32'hCAFEF00D, lat, wec, ma, rd, oth);
        chk("oor_st_we", wec, 0);
        chk("oor_st_lat", lat, 3);
        do_access(0, 0, 32'h0001_0000, 32'h0, lat, wec, ma, rd, oth);
        chk("oor_ld_rdata", rd, 0);
        do_access(0, 0, 32'h0, 32'h0, lat, wec, ma, rd, oth);
        chk("oor_no_alias_wr", rd, 0);

        // Byte-offset bits ignored
        do_access(0, 0, 32'h13, 32'h0, lat, wec, ma, rd, oth);
        chk("unalign_addr", ma, 4);
        chk("unalign_rdata", rd, 32'hDEADBEEF);

        // Reset during RESP of a CPU load
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
        step();
        step();
        rst = 1'b1;
        cpu_req = 0;
        step();
        chk("rstresp_cpu_ack", cpu_ack, 0);
        chk("rstresp_cpu_rdata", cpu_rdata, 0);
        chk("rstresp_mem_addr", mem_addr, 0);
        chk("rstresp_mem_we", mem_we, 0);
        rst = 1'b0;
        step();
        chk("rstresp_no_late_ack", cpu_ack, 0);
        do_access(0, 0, 32'h10, 32'h0, lat, wec, ma, rd, oth);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_rdata", rd, 32'hDEADBEEF);

        // Both held: every (SMAX+1)-th grant goes to DMA
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        dma_req = 1; dma_we = 0; dma_addr = 32'h20;
        k = 0;
        last_dma = -1;
        for (int cyc = 1; cyc <= 75; cyc++) begin
            step();
            if (cpu_ack || dma_ack) begin
                chk("arb_dual_ack", {31'b0, cpu_ack & dma_ack}, 0);
                chk("arb_grant_dma", {31'b0, dma_ack}, ((k % (SMAX + 1)) == SMAX) ? 1 : 0);
                if (dma_ack) begin
                    if (last_dma >= 0) chk("dma_ack_period", cyc - last_dma, 3 * (SMAX + 1));
                    last_dma = cyc;
                end
                $display("arb ack #%0d cyc=%0d cpu=%0d dma=%0d", k, cyc, cpu_ack, dma_ack);
                k++;
            end
        end
        cpu_req = 0;
        dma_req = 0;
        chk("arb_ack_count", k, 25);
        step();
        step();

        // Randomized traffic on both ports
        c_rd_exp = 32'hDEADBEEF;
        d_rd_exp = 32'h12345678;
        cp = 0; dp = 0; cw = 0; dw = 0;
        c_we = 0; d_we = 0; c_a = '0; d_a = '0; c_d = '0; d_d = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (cp) cw++;
            if (dp) dw++;
            if (cpu_ack || dma_ack) chk("rnd_dual_ack", {31'b0, cpu_ack & dma_ack}, 0);
            if (cpu_ack) begin
                chk("rnd_cpu_ack_pending", {31'b0, cp}, 1);
                if (cp) begin
                    model_apply(c_we, c_a, c_d, exp_rd);
                    if (!c_we) c_rd_exp = exp_rd;
                    chk("rnd_cpu_lat_le6", {31'b0, cw <= 6 && cw >= 3}, 1);
                    chk("rnd_cpu_rdata", cpu_rdata, c_rd_exp);
                    chk("rnd_dma_rdata_hold", dma_rdata, d_rd_exp);
                    $display("rnd cpu we=%0d addr=%h wd=%h rd=%h lat=%0d", c_we, c_a, c_d, cpu_rdata, cw);
                    cp = 0;
                    cpu_req = 0;
                end
            end
            if (dma_ack) begin
                chk("rnd_dma_ack_pending", {31'b0, dp}, 1);
                if (dp) begin
                    model_apply(d_we, d_a, d_d, exp_rd);
                    if (!d_we) d_rd_exp = exp_rd;
                    chk("rnd_dma_lat_bound", {31'b0, dw <= 3 * SMAX + 5 && dw >= 3}, 1);
                    chk("rnd_dma_rdata", dma_rdata, d_rd_exp);
                    chk("rnd_cpu_rdata_hold", cpu_rdata, c_rd_exp);
                    $display("rnd dma we=%0d addr=%h wd=%h rd=%h lat=%0d", d_we, d_a, d_d, dma_rdata, dw);
                    dp = 0;
                    dma_req = 0;
                end
            end
            if (cw > 40 || dw > 40) begin
                chk("rnd_wait_timeout", (cw > dw) ? cw : dw, 40);
                break;
            end
            if (!cp && $urandom_range(0, 2) == 0) begin
                c_we = 1'($urandom_range(0, 1));
                c_a  = 32'h100 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
                if ($urandom_range(0, 7) == 0) c_a = c_a | (32'h1 << $urandom_range(AW + 2, 31));
                c_d  = $urandom;
                cp = 1; cw = 0;
                cpu_req = 1; cpu_we = c_we; cpu_addr = c_a; cpu_wdata = c_d;
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                d_we = 1'($urandom_range(0, 1));
                d_a  = 32'h100 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
                if ($urandom_range(0, 7) == 0) d_a = d_a | (32'h1 << $urandom_range(AW + 2, 31));
                d_d  = $urandom;
                dp = 1; dw = 0;
                dma_req = 1; dma_we = d_we; dma_addr = d_a; dma_wdata = d_d;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
